// File: rtl/uart_evt_reg_bank.sv
// Event register bank: per-channel shadow/pend capture, delayed uart_start, frame snapshot, flag stretch.
// Optional build macro UART_EVT_RETRIGGER_EN: strobes during an active flag reload its hold counter.
module uart_evt_reg_bank #(
  parameter int NCH       = 5,
  parameter int DW        = 20,
  parameter int START_DLY = 4,
  parameter int HOLD_CYC  = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_valid,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic              tx_done,
  output logic              uart_start,
  output logic [NCH*DW-1:0] ch_data_o,
  output logic [NCH-1:0]    sent_mask_o,
  output logic [NCH-1:0]    ch_flag_o,
  output logic [NCH-1:0]    overrun_o,
  output logic              busy_o
);

  // state | meaning
  // IDLE  | no frame in flight, waiting for pend != 0
  // ARM   | start delay counting down
  // FIRE  | uart_start high, snapshot presented
  // BUSY  | frame in flight, waiting for tx_done
  typedef enum logic [1:0] {IDLE, ARM, FIRE, BUSY} state_t;

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC);
  // IDLE->ARM takes one edge and ARM->FIRE another, so the counter covers the remaining START_DLY-3 edges.
  localparam logic [3:0] DLY_LOAD = (START_DLY > 2) ? 4'(START_DLY - 3) : 4'd0;

`ifdef UART_EVT_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  state_t              state;
  logic [3:0]          dly_cnt;
  logic [NCH*DW-1:0]   shadow;
  logic [NCH-1:0]      pend;
  logic                fire_now;
  logic [HW-1:0]       hold_cnt [NCH];

  always_comb begin
    fire_now = 1'b0;
    if (state == ARM && dly_cnt == 4'd0)
      fire_now = 1'b1;
    if (state == IDLE && pend != '0 && START_DLY == 2)
      fire_now = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_valid[i])
          shadow[i*DW +: DW] <= ch_data[i*DW +: DW];
      end
    end
  end

  // On the snapshot edge pend restarts from this cycle's strobes, which belong to the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= '0;
      overrun_o <= '0;
    end else begin
      if (fire_now)
        pend <= ch_valid;
      else
        pend <= pend | ch_valid;
      overrun_o <= overrun_o | (ch_valid & pend & ~{NCH{fire_now}});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dly_cnt     <= '0;
      uart_start  <= 1'b0;
      ch_data_o   <= '0;
      sent_mask_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      uart_start <= 1'b0;
      if (fire_now) begin
        state       <= FIRE;
        uart_start  <= 1'b1;
        ch_data_o   <= shadow;
        sent_mask_o <= pend;
        busy_o      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (pend != '0) begin
              state   <= ARM;
              dly_cnt <= DLY_LOAD;
            end
          end
          ARM: dly_cnt <= dly_cnt - 4'd1;
          FIRE: state <= BUSY;
          BUSY: begin
            if (tx_done) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_flag_o <= '0;
      for (int i = 0; i < NCH; i++)
        hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_valid[i] && (RETRIG || hold_cnt[i] == '0)) begin
          hold_cnt[i]  <= HOLD_LD;
          ch_flag_o[i] <= 1'b1;
        end else if (hold_cnt[i] != '0) begin
          hold_cnt[i] <= hold_cnt[i] - 1'b1;
          if (hold_cnt[i] == HW'(1))
            ch_flag_o[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_evt_reg_bank.sv
// Directed bench for uart_evt_reg_bank; expected frames queued at stimulus time, checked on uart_start.
module tb_uart_evt_reg_bank;
  localparam int NCH = 5;
  localparam int DW  = 20;
  localparam int SD  = 4;
  localparam int HC  = 30;
`ifdef UART_EVT_RETRIGGER_EN
  localparam int FLAG_LEN = 50;
`else
  localparam int FLAG_LEN = 30;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   ch_valid;
  logic [NCH*DW-1:0] ch_data;
  logic             tx_done;
  logic             uart_start;
  logic [NCH*DW-1:0] ch_data_o;
  logic [NCH-1:0]   sent_mask_o;
  logic [NCH-1:0]   ch_flag_o;
  logic [NCH-1:0]   overrun_o;
  logic             busy_o;

  uart_evt_reg_bank #(.NCH(NCH), .DW(DW), .START_DLY(SD), .HOLD_CYC(HC)) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data), .tx_done(tx_done),
    .uart_start(uart_start), .ch_data_o(ch_data_o), .sent_mask_o(sent_mask_o),
    .ch_flag_o(ch_flag_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]    mask;
    logic [NCH*DW-1:0] data;
    int                at_edge;
  } frame_t;

  frame_t exp_q[$];
  frame_t mf;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH*DW-1:0] pack5(input logic [19:0] c0, input logic [19:0] c1,
                                              input logic [19:0] c2, input logic [19:0] c3,
                                              input logic [19:0] c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int target, input string tag);
    int n = 0;
    while (start_cnt < target && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 128'(start_cnt >= target), 128'(1'b1));
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (uart_start) begin
      start_cnt++;
      chk("start_expected", 128'(exp_q.size() != 0), 128'(1'b1));
      if (exp_q.size() != 0) begin
        mf = exp_q.pop_front();
        chk("start_edge", 128'(cyc), 128'(mf.at_edge));
        chk("sent_mask", 128'(sent_mask_o), 128'(mf.mask));
        chk("ch_data_o", 128'(ch_data_o), 128'(mf.data));
        chk("busy_at_start", 128'(busy_o), 128'(1'b1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t, s, base;
    logic exp_flag;
    reset = 1'b0; ch_valid = '0; ch_data = '0; tx_done = 1'b0;
    #2 reset = 1'b1;
    tick(); tick();
    chk("rst_uart_start", 128'(uart_start), 128'(1'b0));
    chk("rst_ch_data_o", 128'(ch_data_o), 128'(0));
    chk("rst_sent_mask", 128'(sent_mask_o), 128'(0));
    chk("rst_flag", 128'(ch_flag_o), 128'(0));
    chk("rst_overrun", 128'(overrun_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(1'b0));
    reset = 1'b0;
    repeat (3) tick();

    // single event on ch2
    ch_valid = 5'b00100; ch_data = pack5(0, 0, 20'hABCDE, 0, 0);
    tick(); k = cyc;
    exp_q.push_back('{5'b00100, pack5(0, 0, 20'hABCDE, 0, 0), k + SD - 1});
    ch_valid = '0;
    wait_start(1, "frame1_seen");
    chk("busy_frame1", 128'(busy_o), 128'(1'b1));

    // ch0 during BUSY must not disturb the frozen snapshot
    ch_valid = 5'b00001; ch_data = pack5(20'h12345, 0, 0, 0, 0);
    tick(); ch_valid = '0; tick();
    chk("freeze_data", 128'(ch_data_o), 128'(pack5(0, 0, 20'hABCDE, 0, 0)));
    chk("freeze_mask", 128'(sent_mask_o), 128'(5'b00100));
    chk("freeze_busy", 128'(busy_o), 128'(1'b1));
    repeat (3) tick();
    pulse_done(); t = cyc;
    exp_q.push_back('{5'b00001, pack5(20'h12345, 0, 20'hABCDE, 0, 0), t + SD - 1});
    chk("busy_cleared", 128'(busy_o), 128'(1'b0));
    wait_start(2, "frame2_seen");
    pulse_done();
    repeat (2) tick();

    // overrun: two ch1 strobes one cycle apart
    base = start_cnt;
    ch_valid = 5'b00010; ch_data = pack5(0, 20'hA1111, 0, 0, 0);
    tick(); k = cyc;
    exp_q.push_back('{5'b00010, pack5(20'h12345, 20'hA2222, 20'hABCDE, 0, 0), k + SD - 1});
    ch_valid = '0; tick();
    ch_valid = 5'b00010; ch_data = pack5(0, 20'hA2222, 0, 0, 0);
    tick(); ch_valid = '0;
    chk("overrun_set", 128'(overrun_o), 128'(5'b00010));
    wait_start(base + 1, "frame3_seen");
    pulse_done();
    repeat (20) tick();
    chk("single_start", 128'(start_cnt), 128'(base + 1));

    // ch3 strobe in FIRE cycle, ch4 strobe with tx_done
    ch_valid = 5'b00001; ch_data = pack5(20'h55555, 0, 0, 0, 0);
    tick(); k = cyc;
    exp_q.push_back('{5'b00001, pack5(20'h55555, 20'hA2222, 20'hABCDE, 0, 0), k + SD - 1});
    ch_valid = '0;
    tick(); tick(); tick();
    chk("fire_cycle", 128'(uart_start), 128'(1'b1));
    ch_valid = 5'b01000; ch_data = pack5(0, 0, 0, 20'h33333, 0);
    tick(); ch_valid = '0;
    repeat (3) tick();
    ch_valid = 5'b10000; ch_data = pack5(0, 0, 0, 0, 20'h44444); tx_done = 1'b1;
    tick(); t = cyc;
    ch_valid = '0; tx_done = 1'b0;
    exp_q.push_back('{5'b11000, pack5(20'h55555, 20'hA2222, 20'hABCDE, 20'h33333, 20'h44444), t + SD - 1});
    wait_start(base + 3, "frame5_seen");
    pulse_done();
    chk("overrun_sticky", 128'(overrun_o), 128'(5'b00010));
    repeat (40) tick();

    // stretch: ch2 strobes at edges s and s+20
    ch_valid = 5'b00100; ch_data = pack5(0, 0, 20'h22222, 0, 0);
    tick(); s = cyc;
    exp_q.push_back('{5'b00100, pack5(20'h55555, 20'hA2222, 20'h22222, 20'h33333, 20'h44444), s + SD - 1});
    for (int j = 0; j < 56; j++) begin
      exp_flag = (j < FLAG_LEN);
      chk("flag_stretch", 128'(ch_flag_o[2]), 128'(exp_flag));
      if (j == 19) begin
        ch_valid = 5'b00100; ch_data = pack5(0, 0, 20'h2BBBB, 0, 0);
      end else begin
        ch_valid = '0;
      end
      tick();
    end
    ch_valid = '0;
    pulse_done(); t = cyc;
    exp_q.push_back('{5'b00100, pack5(20'h55555, 20'hA2222, 20'h2BBBB, 20'h33333, 20'h44444), t + SD - 1});
    wait_start(base + 5, "frame7_seen");

    // reset mid-frame with a pending ch1 event
    ch_valid = 5'b00010; ch_data = pack5(0, 20'hA3333, 0, 0, 0);
    tick(); ch_valid = '0;
    chk("busy_before_reset", 128'(busy_o), 128'(1'b1));
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_uart_start", 128'(uart_start), 128'(1'b0));
    chk("mid_rst_ch_data_o", 128'(ch_data_o), 128'(0));
    chk("mid_rst_sent_mask", 128'(sent_mask_o), 128'(0));
    chk("mid_rst_flag", 128'(ch_flag_o), 128'(0));
    chk("mid_rst_overrun", 128'(overrun_o), 128'(0));
    chk("mid_rst_busy", 128'(busy_o), 128'(1'b0));
    tick();
    reset = 1'b0;
    base = start_cnt;
    repeat (100) tick();
    chk("no_start_after_reset", 128'(start_cnt), 128'(base));
    chk("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
